mem_port_sequencer: RTL and testbench
=====================================

Name: mem_port_sequencer

Overview:
- Shares one single-port memory slave between the CPU instruction-fetch port and data port.
- For every CPU step it performs at most one data access, then exactly one instruction fetch.
- Holds cpu_stall high until both accesses complete.
- Sits between cpu and the memory/peripheral slave side of the arbiter.
- Tolerates variable-latency slaves through a request/ready handshake, with a bounded timeout.

Parameters:
- TIMEOUT, 255: maximum wait cycles per access before abort (1..255); the counter is 8 bits.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- iaddr  in  32  instruction fetch address from cpu.
- iin  out  32  fetched instruction to cpu (registered).
- daddr  in  32  data address from cpu.
- dout  in  32  store data from cpu.
- drw  in  2  data op: 00 none, 01 read, 10 write, 11 illegal.
- din  out  32  load data to cpu (registered).
- cpu_stall  out  1  1 = cpu must hold state and ports.
- mem_addr  out  32  slave address.
- mem_wdata  out  32  slave write data.
- mem_rd  out  1  slave read strobe; level, held until ready.
- mem_wr  out  1  slave write strobe; level, held until ready.
- mem_rdata  in  32  slave read data, valid when mem_ready=1.
- mem_ready  in  1  slave completion; sampled only while a strobe is high.
- bus_err  out  1  one-cycle pulse on timeout or illegal drw.

Behaviour:
- Reset values: state=CAPTURE, cpu_stall=1, iin=0, din=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, bus_err=0, timeout counter=0.
- States are CAPTURE, DATA, INST, DONE. All outputs are registered; strobes change only on clock edges.
- CAPTURE: latch iaddr, daddr, dout, drw into internal registers; cpu_stall=1.
  - drw=01 or 10: go to DATA; drive mem_addr=daddr, mem_wdata=dout, and mem_rd or mem_wr accordingly.
  - drw=00: go to INST with mem_addr=iaddr, mem_rd=1.
  - drw=11: pulse bus_err, leave din unchanged, go to INST.
- DATA: strobe held and counter incremented each cycle.
  - On mem_ready=1: for a read, din<=mem_rdata; for a write, din is unchanged. Drop strobes, go to INST issuing the fetch on the same edge (mem_addr=latched iaddr, mem_rd=1), counter cleared.
  - If counter reaches TIMEOUT-1 with mem_ready=0: abort. A read returns din<=0. Pulse bus_err, go to INST as above.
- INST: on mem_ready=1, iin<=mem_rdata, mem_rd<=0, go to DONE. On timeout, iin<=0 (nop), bus_err pulse, go to DONE.
- DONE: cpu_stall=0 for exactly one cycle; iin/din valid. The cpu advances on this edge. Next state is CAPTURE, with cpu_stall=1 again.
- Latency with zero-wait slave (ready in first strobe cycle): 3 cycles per step with no data op, 4 cycles with a data op. Each wait cycle adds 1.
- The data access always precedes the fetch; strobes are never both high; a strobe never lasts more than TIMEOUT cycles.
- mem_ready while no strobe is asserted: ignored; no state change.
- Inputs changing during DATA/INST: ignored; only the latched values are used.
- Reset mid-access: at the next edge, strobes drop, state goes to CAPTURE, all outputs take their reset values. Any partial result is discarded.
- TIMEOUT compare is on an 8-bit counter; no wrap is possible, since the counter clears on every access start.

Test Plan:
- Zero-wait slave, drw=00, iaddr=0x10000000, slave returns 0x3C011234:
  - mem_rd high 1 cycle at mem_addr 0x10000000.
  - cpu_stall low exactly 1 cycle on the 3rd cycle after CAPTURE.
  - iin=0x3C011234, din unchanged.
- Read then fetch:
  - Stimulus: drw=01, daddr=0xF0200000, slave data 0x000000AA then 0x00000000, ready delayed 2 cycles each.
  - Response: mem_rd at 0xF0200000 for 3 cycles, then at iaddr for 3 cycles, din=0x000000AA, stall-low pulse after 8 cycles.
- Write, drw=10, daddr=0xF0100000, dout=0x0000005A:
  - mem_wr=1 with mem_wdata=0x5A until ready, mem_rd=0 throughout.
  - din retains its prior value; fetch follows.
- Timeout, TIMEOUT=4, slave never ready on data read:
  - mem_rd high 4 cycles, bus_err pulses once, din=0.
  - Fetch then proceeds normally.
- drw=11 and spurious mem_ready while idle:
  - No mem_wr/mem_rd for data; bus_err one pulse.
  - Spurious ready causes no state change.
- Assert rst during INST wait:
  - Next edge: mem_rd=0, cpu_stall=1, iin=0, din=0.
  - After release the sequence restarts from CAPTURE with fresh inputs.

Source files
------------

// File: rtl/mem_port_sequencer.sv
// rtl/mem_port_sequencer.sv - shares one single-port memory slave between cpu data and fetch ports
// One optional data access then one fetch per cpu step, with a bounded ready wait per access.
module mem_port_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iaddr,
  output logic [31:0] iin,
  input  logic [31:0] daddr,
  input  logic [31:0] dout,
  input  logic [1:0]  drw,
  output logic [31:0] din,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_err
);

  typedef enum logic [1:0] {CAPTURE, DATA, INST, DONE} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [31:0] iaddr_q, iaddr_n;
  logic [1:0]  drw_q, drw_n;
  logic [7:0]  cnt, cnt_n;
  logic [31:0] iin_n, din_n, addr_n, wdata_n;
  logic        stall_n, rd_n, wr_n, err_n;

  always_comb begin
    state_n = state;
    iaddr_n = iaddr_q;
    drw_n   = drw_q;
    cnt_n   = cnt;
    iin_n   = iin;
    din_n   = din;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    rd_n    = mem_rd;
    wr_n    = mem_wr;
    stall_n = 1'b1;
    err_n   = 1'b0;

    case (state)
      CAPTURE: begin
        iaddr_n = iaddr;
        drw_n   = drw;
        cnt_n   = 8'd0;
        case (drw)
          2'b01, 2'b10: begin
            state_n = DATA;
            addr_n  = daddr;
            wdata_n = dout;
            rd_n    = (drw == 2'b01);
            wr_n    = (drw == 2'b10);
          end
          default: begin
            // An illegal op is flagged and skipped; the fetch still happens.
            err_n   = (drw == 2'b11);
            state_n = INST;
            addr_n  = iaddr;
            rd_n    = 1'b1;
            wr_n    = 1'b0;
          end
        endcase
      end

      DATA: begin
        if (mem_ready || cnt == LAST_WAIT) begin
          if (drw_q == 2'b01) begin
            din_n = mem_ready ? mem_rdata : 32'd0;
          end
          err_n   = !mem_ready;
          // The fetch is issued on the same edge the data access retires.
          state_n = INST;
          addr_n  = iaddr_q;
          rd_n    = 1'b1;
          wr_n    = 1'b0;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end

      INST: begin
        if (mem_ready || cnt == LAST_WAIT) begin
          iin_n   = mem_ready ? mem_rdata : 32'd0;
          err_n   = !mem_ready;
          rd_n    = 1'b0;
          state_n = DONE;
          stall_n = 1'b0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end

      DONE: begin
        state_n = CAPTURE;
      end

      default: begin
        state_n = CAPTURE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CAPTURE;
      iaddr_q   <= 32'd0;
      drw_q     <= 2'b00;
      cnt       <= 8'd0;
      iin       <= 32'd0;
      din       <= 32'd0;
      cpu_stall <= 1'b1;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_n;
      iaddr_q   <= iaddr_n;
      drw_q     <= drw_n;
      cnt       <= cnt_n;
      iin       <= iin_n;
      din       <= din_n;
      cpu_stall <= stall_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      mem_rd    <= rd_n;
      mem_wr    <= wr_n;
      bus_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// tb/tb_mem_port_sequencer.sv - randomized self-checking bench for mem_port_sequencer
module tb_mem_port_sequencer;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iaddr, iin, daddr, dout, din;
  logic [1:0]  drw;
  logic        cpu_stall, mem_rd, mem_wr, mem_ready, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] din_model = 32'd0;

  mem_port_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .iaddr(iaddr), .iin(iin), .daddr(daddr), .dout(dout),
    .drw(drw), .din(din), .cpu_stall(cpu_stall), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Entered and left at the negedge of a CAPTURE cycle; ia and da must differ.
  task automatic run_step(input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dw,
                          input logic [1:0] op, input int wd, input int wi,
                          input logic [31:0] rdd, input logic [31:0] rdi);
    int  dcnt = 0, icnt = 0, wrcnt = 0, errcnt = 0, both = 0, badaddr = 0, wdbad = 0, cyc = 0;
    bit  done = 0;
    bit  has_data, dto, ito;
    int  exp_dcyc, exp_icyc, exp_errs;
    logic [31:0] exp_iin;

    has_data = (op == 2'b01) || (op == 2'b10);
    dto      = has_data && (wd >= TO);
    ito      = (wi >= TO);
    exp_dcyc = has_data ? (dto ? TO : wd + 1) : 0;
    exp_icyc = ito ? TO : wi + 1;
    exp_errs = int'(op == 2'b11) + int'(dto) + int'(ito);
    exp_iin  = ito ? 32'd0 : rdi;
    if (op == 2'b01) din_model = dto ? 32'd0 : rdd;

    iaddr = ia; daddr = da; dout = dw; drw = op;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;

    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      // Later cpu inputs must have no effect once captured.
      iaddr = $urandom; daddr = $urandom; dout = $urandom; drw = 2'($urandom);
      if (bus_err) errcnt++;
      if (mem_rd && mem_wr) both++;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (!cpu_stall) begin
        done = 1;
        mem_ready = 1'($urandom_range(0, 1));
      end else if (mem_rd || mem_wr) begin
        if (mem_addr == da) begin
          if (dcnt == wd) begin mem_ready = 1'b1; mem_rdata = rdd; end
          dcnt++;
          if (mem_wr) begin
            wrcnt++;
            if (mem_wdata !== dw) wdbad++;
          end
        end else if (mem_addr == ia && mem_rd) begin
          if (icnt == wi) begin mem_ready = 1'b1; mem_rdata = rdi; end
          icnt++;
        end else begin
          badaddr++;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
    end

    check_eq("stall_low_seen", 32'(done), 32'd1);
    check_eq("step_cycles", 32'(cyc), 32'(exp_dcyc + exp_icyc + 1));
    check_eq("iin", iin, exp_iin);
    check_eq("din", din, din_model);
    check_eq("bus_err_pulses", 32'(errcnt), 32'(exp_errs));
    check_eq("data_strobe_cycles", 32'(dcnt), 32'(exp_dcyc));
    check_eq("write_strobe_cycles", 32'(wrcnt), 32'((op == 2'b10) ? exp_dcyc : 0));
    check_eq("fetch_strobe_cycles", 32'(icnt), 32'(exp_icyc));
    check_eq("both_strobes", 32'(both), 32'd0);
    check_eq("bad_addr_cycles", 32'(badaddr), 32'd0);
    check_eq("wdata_bad", 32'(wdbad), 32'd0);
    @(negedge clk);
    check_eq("stall_back_high", 32'(cpu_stall), 32'd1);
    check_eq("strobes_idle", {30'd0, mem_rd, mem_wr}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rd_wr"}, {30'd0, mem_rd, mem_wr}, 32'd0);
    check_eq({tag, "_stall"}, 32'(cpu_stall), 32'd1);
    check_eq({tag, "_iin"}, iin, 32'd0);
    check_eq({tag, "_din"}, din, 32'd0);
    check_eq({tag, "_addr"}, mem_addr, 32'd0);
    check_eq({tag, "_wdata"}, mem_wdata, 32'd0);
    check_eq({tag, "_bus_err"}, 32'(bus_err), 32'd0);
  endtask

  initial begin
    logic [31:0] ia, da;
    rst = 1'b1; iaddr = '0; daddr = '0; dout = '0; drw = 2'b00;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    run_step(32'h1000_0000, 32'h9000_0000, 32'h0, 2'b00, 0, 0, 32'h0, 32'h3C01_1234);
    run_step(32'h0000_0400, 32'hF020_0000, 32'h0, 2'b01, 2, 2, 32'h0000_00AA, 32'h0);
    run_step(32'h0000_0404, 32'hF010_0000, 32'h5A, 2'b10, 1, 0, 32'h1234_5678, 32'h2402_0001);
    run_step(32'h0000_0408, 32'hF020_0004, 32'h0, 2'b01, TO, 1, 32'hDEAD_BEEF, 32'h0000_0021);
    run_step(32'h0000_040C, 32'hF030_0000, 32'h77, 2'b11, 6, 0, 32'h5555_5555, 32'h2403_0002);
    run_step(32'h0000_0410, 32'hF020_0008, 32'h0, 2'b01, 0, 1, 32'hCAFE_F00D, 32'h0000_0042);

    // Reset asserted while the fetch is waiting on the slave.
    iaddr = 32'h0000_0500; daddr = 32'h8000_0000; drw = 2'b00; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("inst_wait_rd", 32'(mem_rd), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    din_model = 32'd0;

    for (int k = 0; k < 60; k++) begin
      ia = $urandom;
      da = {~ia[31], 31'($urandom)};
      run_step(ia, da, $urandom, 2'($urandom), int'($urandom_range(0, TO + 1)),
               int'($urandom_range(0, TO + 1)), $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
